dir_buttons: RTL and testbench

Conditions the five raw push-button inputs (four directions plus select) for the 6×6 board logic, which consumes one-cycle move pulses.
- Each button is synchronised, debounced and edge-detected.
- Simultaneous direction presses are arbitrated so at most one direction pulse leaves per cycle.
- The pulses drive the cursor stage's up/down/left/right inputs directly; sel goes to the tile-pick logic.

---
 rtl/dir_buttons_pkg.sv | 45 ++++
 rtl/dir_buttons_btn_debounce.sv | 159 +++++++++++++++
 rtl/dir_buttons.sv | 93 +++++++++
 tb/tb_dir_buttons.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dir_buttons_pkg.sv
// dir_buttons_pkg
// Shared definitions for the push-button conditioning block: button bit
// indices (same order as btn_raw), the per-button debounce state encoding,
// default cycle constants and the fixed-priority direction picker.
// Optional feature macro used by the design: DIR_BUTTONS_AUTOREPEAT_EN.
package dir_buttons_pkg;

  localparam int NUM_BTN   = 5;
  localparam int BTN_SEL   = 4;
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 40000000;
  localparam int DEF_REPEAT_PERIOD   = 10000000;

  typedef enum logic [1:0] {
    ST_REL       = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_PRS       = 2'd2,
    ST_REL_CHK   = 2'd3
  } db_state_e;

  // Keep only the highest-priority direction event: up > down > left > right.
  // Lower-priority coincident events are dropped, never queued.
  function automatic logic [3:0] prio_pick(input logic [3:0] evt);
    logic [3:0] grant;
    grant = 4'b0000;
    if (evt[BTN_UP]) begin
      grant[BTN_UP] = 1'b1;
    end else if (evt[BTN_DOWN]) begin
      grant[BTN_DOWN] = 1'b1;
    end else if (evt[BTN_LEFT]) begin
      grant[BTN_LEFT] = 1'b1;
    end else if (evt[BTN_RIGHT]) begin
      grant[BTN_RIGHT] = 1'b1;
    end else begin
      grant = 4'b0000;
    end
    return grant;
  endfunction

endpackage

// File: rtl/dir_buttons_btn_debounce.sv
// btn_debounce
// One button channel: 2-flop synchroniser, debounce FSM with a saturating
// stability counter and, when DIR_BUTTONS_AUTOREPEAT_EN is defined, a repeat
// counter that runs while the button sits in the pressed state.
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   i_raw     raw, bouncy, asynchronous pad level
//   o_held    debounced level (registered)
//   o_press   press event, high for the one cycle before the level is accepted
//   o_repeat  auto-repeat event (constant 0 without the repeat build)
module btn_debounce
  import dir_buttons_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef DIR_BUTTONS_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN       = 1'b1
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_held,
  output logic o_press,
  output logic o_repeat
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  // The sample that moves the FSM out of a steady state is the first stable
  // sample, so the counter only has to cover the remaining DEBOUNCE_CYCLES-1;
  // the level is accepted on the sample taken while it reads DEBOUNCE_CYCLES-2.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic      r_sync1;
  logic      r_sync2;
  logic      w_s;
  db_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic      r_held;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  assign w_s = r_sync2;

  // Two-flop synchroniser for the asynchronous pad.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign o_press = (r_state == ST_PRESS_CHK) && w_s && (r_cnt == CNT_LAST);

  // Debounce FSM, stability counter and registered debounced level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_REL;
      r_cnt   <= CNT_ZERO;
      r_held  <= 1'b0;
    end else begin
      case (r_state)
        ST_REL: begin
          r_cnt <= CNT_ZERO;
          if (w_s) begin
            r_state <= ST_PRESS_CHK;
          end else begin
            r_state <= ST_REL;
          end
        end
        ST_PRESS_CHK: begin
          if (!w_s) begin
            r_state <= ST_REL;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_PRS;
            r_cnt   <= CNT_ZERO;
            r_held  <= 1'b1;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        ST_PRS: begin
          r_cnt <= CNT_ZERO;
          if (!w_s) begin
            r_state <= ST_REL_CHK;
          end else begin
            r_state <= ST_PRS;
          end
        end
        ST_REL_CHK: begin
          if (w_s) begin
            // Bounce back while releasing: still pressed, no new event.
            r_state <= ST_PRS;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_REL;
            r_cnt   <= CNT_ZERO;
            r_held  <= 1'b0;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        default: begin
          r_state <= ST_REL;
          r_cnt   <= CNT_ZERO;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign o_held = r_held;

`ifdef DIR_BUTTONS_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY);
  localparam logic [RW-1:0] RCNT_ZERO   = {RW{1'b0}};
  localparam logic [RW-1:0] RCNT_ONE    = RW'(1);
  localparam logic [RW-1:0] RCNT_FIRE   = RW'(REPEAT_DELAY - 1);
  // After a repeat fires the counter restarts part-way so the next one comes
  // REPEAT_PERIOD cycles later at the same terminal value.
  localparam logic [RW-1:0] RCNT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RW-1:0] r_rcnt;
  logic          w_stay_prs;

  assign w_stay_prs = REPEAT_EN && (r_state == ST_PRS) && w_s;
  assign o_repeat   = w_stay_prs && (r_rcnt == RCNT_FIRE);

  // Repeat counter: runs only while the button remains in the pressed state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rcnt <= RCNT_ZERO;
    end else if (w_stay_prs) begin
      if (r_rcnt == RCNT_FIRE) begin
        r_rcnt <= RCNT_RELOAD;
      end else begin
        r_rcnt <= r_rcnt + RCNT_ONE;
      end
    end else begin
      r_rcnt <= RCNT_ZERO;
    end
  end
`else
  assign o_repeat = 1'b0;
`endif

endmodule

// File: rtl/dir_buttons.sv
// dir_buttons
// Conditions the five raw push buttons for the board logic: each button is
// synchronised, debounced and edge-detected; direction events are reduced
// to at most one pulse per cycle by fixed priority up > down > left > right.
// Optional feature macro: DIR_BUTTONS_AUTOREPEAT_EN (adds held-direction
// auto-repeat and the REPEAT_DELAY / REPEAT_PERIOD parameters).
// Ports:
//   clk                    system clock
//   rst                    asynchronous active-low reset
//   btn_raw[4:0]           raw pads {sel, up, down, left, right}
//   up/down/left/right     one-cycle move pulses, mutually exclusive
//   sel                    one-cycle select pulse, not arbitrated
//   held[4:0]              debounced level per button, btn_raw bit order
module dir_buttons
  import dir_buttons_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef DIR_BUTTONS_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       sel,
  output logic [4:0] held
);

  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_rep;
  logic [NUM_BTN-1:0] w_held;
  logic [3:0]         w_dir_grant;
  logic               r_up;
  logic               r_down;
  logic               r_left;
  logic               r_right;
  logic               r_sel;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef DIR_BUTTONS_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (g != BTN_SEL)
`endif
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (btn_raw[g]),
      .o_held  (w_held[g]),
      .o_press (w_press[g]),
      .o_repeat(w_rep[g])
    );
  end

  assign w_dir_grant = prio_pick(w_press[3:0] | w_rep[3:0]);

  // Output pulse registers; events land here so each pulse is one cycle wide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_up    <= 1'b0;
      r_down  <= 1'b0;
      r_left  <= 1'b0;
      r_right <= 1'b0;
      r_sel   <= 1'b0;
    end else begin
      r_up    <= w_dir_grant[BTN_UP];
      r_down  <= w_dir_grant[BTN_DOWN];
      r_left  <= w_dir_grant[BTN_LEFT];
      r_right <= w_dir_grant[BTN_RIGHT];
      // The sel channel is built without repeat, so its repeat term is zero.
      r_sel   <= w_press[BTN_SEL] | w_rep[BTN_SEL];
    end
  end

  assign up    = r_up;
  assign down  = r_down;
  assign left  = r_left;
  assign right = r_right;
  assign sel   = r_sel;
  // Debounced levels are already registered inside each channel and switch
  // on the same edge that loads the press pulse.
  assign held  = w_held;

endmodule

// File: tb/tb_dir_buttons.sv
module tb_dir_buttons;
  localparam int DC = 4;
  localparam int RD = 20;
  localparam int RP = 8;
`ifdef DIR_BUTTONS_AUTOREPEAT_EN
  localparam int EXP_LEFT = 6;
`else
  localparam int EXP_LEFT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn_raw;
  logic       up, down, left, right, sel;
  logic [4:0] held;

  always #5 clk = ~clk;

  dir_buttons #(
    .DEBOUNCE_CYCLES(DC)
`ifdef DIR_BUTTONS_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
`endif
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_raw),
    .up     (up),
    .down   (down),
    .left   (left),
    .right  (right),
    .sel    (sel),
    .held   (held)
  );

  typedef struct {
    int         t;
    logic [4:0] v;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // monitor-owned observations
  int n_left = 0, n_right = 0, n_up = 0;
  int last_sel_cyc = -1, last_down_cyc = -1;

  // Reference model: raw delayed two clocks, then a level flips once DC
  // consecutive samples disagree with it. Repeats are counted from the cycle
  // the steady-held condition began.
  logic [4:0] m_s1, m_s2, m_lvl;
  int m_run[5];
  int m_t0[5];

  initial begin
    m_s1 = 5'b0; m_s2 = 5'b0; m_lvl = 5'b0;
    for (int i = 0; i < 5; i++) begin m_run[i] = 0; m_t0[i] = 0; end
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        m_s1 = 5'b0; m_s2 = 5'b0; m_lvl = 5'b0;
        for (int i = 0; i < 5; i++) m_run[i] = 0;
      end else begin
        logic [4:0] smp, rise, rep, ev;
        logic [3:0] dir;
        logic       steady;
        smp = m_s2; rise = 5'b0; rep = 5'b0;
        for (int i = 0; i < 5; i++) begin
          steady = m_lvl[i] && (m_run[i] == 0);
          if (smp[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DC) begin
              m_lvl[i] = ~m_lvl[i];
              m_run[i] = 0;
              if (m_lvl[i]) begin rise[i] = 1'b1; m_t0[i] = cyc; end
            end
          end else begin
            m_run[i] = 0;
            if (m_lvl[i] && !steady) m_t0[i] = cyc;
`ifdef DIR_BUTTONS_AUTOREPEAT_EN
            if (i != 4 && steady) begin
              int k;
              k = cyc - m_t0[i];
              if (k >= RD && ((k - RD) % RP) == 0) rep[i] = 1'b1;
            end
`endif
          end
        end
        m_s2 = m_s1;
        m_s1 = btn_raw;
        dir = rise[3:0] | rep[3:0];
        if (dir[3])      ev = {rise[4], 4'b1000};
        else if (dir[2]) ev = {rise[4], 4'b0100};
        else if (dir[1]) ev = {rise[4], 4'b0010};
        else if (dir[0]) ev = {rise[4], 4'b0001};
        else             ev = {rise[4], 4'b0000};
        if (ev != 5'b0) q.push_back('{cyc, ev});
      end
    end
  end

  // Monitor: pops expected pulses whenever the DUT shows one; checks held.
  initial begin
    forever begin
      logic [4:0] dv;
      exp_t e;
      @(negedge clk);
      if (rst === 1'b1) begin
        dv = {sel, up, down, left, right};
        while (q.size() > 0 && q[0].t < cyc) begin
          checks++; errors++;
          $display("FAIL missed_pulse cycle %0d: dut none, required %b at cycle %0d", cyc, q[0].v, q[0].t);
          void'(q.pop_front());
        end
        if (dv != 5'b0) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL spurious_pulse cycle %0d: dut %b, required none", cyc, dv);
          end else begin
            e = q.pop_front();
            if (e.t != cyc || e.v != dv) begin
              errors++;
              $display("FAIL pulse cycle %0d: dut %b, required %b at cycle %0d", cyc, dv, e.v, e.t);
            end
          end
          if (left)  n_left++;
          if (right) n_right++;
          if (up)    n_up++;
          if (sel)   last_sel_cyc = cyc;
          if (down)  last_down_cyc = cyc;
        end
        checks++;
        if (held !== m_lvl) begin
          errors++;
          $display("FAIL held cycle %0d: dut %b, required %b", cyc, held, m_lvl);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({up, down, left, right, sel} !== 5'b0 || held !== 5'b0) begin
      errors++;
      $display("FAIL %s: dut pulses %b held %b, required all 0", name, {sel, up, down, left, right}, held);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: dut %0d, required %0d", name, act, req);
    end
  endtask

  initial begin
    int t_press, lat, snap, snap2, r;
    bit found;
    int hc[5];
    rst = 1'b0; btn_raw = 5'b0;
    wait_cyc(3);
    check_zero("reset_state");
    rst = 1'b1;
    wait_cyc(3);

    // 1: clean up press held 50 cycles
    btn_raw[3] = 1'b1; t_press = cyc; found = 0; lat = -1;
    for (int k = 0; k < 20 && !found; k++) begin
      wait_cyc(1);
      if (up) begin found = 1; lat = cyc - t_press; end
    end
    checks++;
    if (!found || lat < 5 || lat > 7) begin
      errors++;
      $display("FAIL up_latency: dut %0d cycles, required 6+-1", lat);
    end
    snap = n_up;
    wait_cyc(50 - lat);
    check_int("up_single_pulse", n_up - snap, 0);
    btn_raw[3] = 1'b0; r = cyc;
    wait_cyc(5);
    check_int("held_up_before_release_debounce", int'(held[3]), 1);
    wait_cyc(1);
    check_int("held_up_after_release_debounce", int'(held[3]), 0);
    wait_cyc(10);

    // 2: bouncing right then stable
    snap = n_right;
    for (int k = 0; k < 2; k++) begin
      btn_raw[0] = 1'b1; wait_cyc(2);
      btn_raw[0] = 1'b0; wait_cyc(2);
    end
    btn_raw[0] = 1'b1; wait_cyc(20);
    check_int("right_bounce_pulses", n_right - snap, 1);
    btn_raw[0] = 1'b0; wait_cyc(12);

    // 3: up and left together
    snap = n_up; snap2 = n_left;
    btn_raw[3] = 1'b1; btn_raw[1] = 1'b1;
    wait_cyc(10);
    check_int("held_up_left", int'({held[3], held[1]}), 3);
    wait_cyc(5);
    check_int("coincident_up_pulses", n_up - snap, 1);
    check_int("coincident_left_dropped", n_left - snap2, 0);
    btn_raw[3] = 1'b0; btn_raw[1] = 1'b0; wait_cyc(12);

    // 4: reset during press check of down
    btn_raw[2] = 1'b1;
    wait_cyc(5);
    rst = 1'b0; #1;
    check_zero("reset_mid_count");
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(15);
    btn_raw[2] = 1'b0; wait_cyc(12);

    // 5: sel and down together
    btn_raw[4] = 1'b1; btn_raw[2] = 1'b1;
    wait_cyc(12);
    checks++;
    if (last_sel_cyc < 0 || last_sel_cyc != last_down_cyc) begin
      errors++;
      $display("FAIL sel_down_same_cycle: dut sel@%0d down@%0d, required equal", last_sel_cyc, last_down_cyc);
    end
    btn_raw[4] = 1'b0; btn_raw[2] = 1'b0; wait_cyc(12);

    // 6: left held 60 cycles
    snap = n_left;
    btn_raw[1] = 1'b1; wait_cyc(60);
    btn_raw[1] = 1'b0; wait_cyc(12);
    check_int("left_hold_pulses", n_left - snap, EXP_LEFT);

    // random phase
    for (int i = 0; i < 5; i++) hc[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 5; i++) begin
        if (hc[i] == 0) begin
          btn_raw[i] = 1'($urandom_range(0, 1));
          hc[i] = $urandom_range(1, 12);
        end else begin
          hc[i]--;
        end
      end
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0; #1;
        check_zero("random_reset");
        wait_cyc(2);
        rst = 1'b1;
      end
      wait_cyc(1);
    end
    btn_raw = 5'b0;
    wait_cyc(20);
    check_int("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
